// File: rtl/dbus_arbiter_pkg.sv
// Shared types and constants for the data-bus arbiter slice.
package dbus_arbiter_pkg;

  typedef enum logic {
    DARB_IDLE = 1'b0,
    DARB_BUSY = 1'b1
  } darb_state_e;

  localparam logic DARB_M0 = 1'b0;
  localparam logic DARB_M1 = 1'b1;

  // Largest wait-state count the 4-bit counter can hold.
  localparam int DARB_WAIT_MAX = 15;
  localparam int DARB_CNT_W    = 4;

  // Clamp a requested wait-state count into the counter's legal range.
  function automatic logic [DARB_CNT_W-1:0] darb_wait_load(input int wait_cycles);
    logic [DARB_CNT_W-1:0] val;
    if (wait_cycles < 0) begin
      val = '0;
    end else if (wait_cycles > DARB_WAIT_MAX) begin
      val = DARB_CNT_W'(DARB_WAIT_MAX);
    end else begin
      val = DARB_CNT_W'(wait_cycles);
    end
    return val;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that did not win last time.
module rr_pick2
  import dbus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick the winner from the eligible set and the previous winner.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = DARB_M0;
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else if (req[1]) begin
      gnt_id = DARB_M1;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter: shares the bridge port between the CPU MEM stage (M0)
// and an auxiliary master (M1), with fixed wait states and a one-cycle ack.
// Optional performance counters are enabled by defining DBUS_ARB_PERF_EN.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic          bus_wen,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          cpu_stall,
  output logic          owner
`ifdef DBUS_ARB_PERF_EN
  ,
  output logic [31:0]   perf_conflict,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [DARB_CNT_W-1:0] WAIT_LD = darb_wait_load(WAIT_CYCLES);

  darb_state_e           state_q, state_d;
  logic [DARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  owner_d;
  logic [AW-1:0]         addr_d;
  logic                  wen_d;
  logic [DW-1:0]         wdata_d;
  logic                  ack0_d, ack1_d;
  logic [DW-1:0]         rdata0_d, rdata1_d;
  logic [1:0]            req_eff;
  logic                  gnt_valid;
  logic                  gnt_id;

  // A master acked this cycle is masked so it cannot be granted twice.
  assign req_eff   = {m1_req & ~m1_ack, m0_req & ~m0_ack};
  assign cpu_stall = m0_req & ~m0_ack;

  rr_pick2 u_pick (
    .req       (req_eff),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next-state, wait counter and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner;
    addr_d   = bus_addr;
    wen_d    = 1'b0;
    wdata_d  = bus_wdata;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = m0_rdata;
    rdata1_d = m1_rdata;
    case (state_q)
      DARB_IDLE: begin
        addr_d  = '0;
        wdata_d = '0;
        if (gnt_valid) begin
          state_d = DARB_BUSY;
          owner_d = gnt_id;
          last_d  = gnt_id;
          cnt_d   = WAIT_LD;
          if (gnt_id == DARB_M1) begin
            addr_d  = m1_addr;
            wen_d   = m1_we;
            wdata_d = m1_wdata;
          end else begin
            addr_d  = m0_addr;
            wen_d   = m0_we;
            wdata_d = m0_wdata;
          end
        end
      end
      DARB_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DARB_CNT_W'(1);
        end else begin
          if (owner == DARB_M1) begin
            ack1_d   = 1'b1;
            rdata1_d = bus_rdata;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = bus_rdata;
          end
          addr_d  = '0;
          wdata_d = '0;
          state_d = DARB_IDLE;
        end
      end
      default: state_d = DARB_IDLE;
    endcase
  end

  // FSM state, wait counter and round-robin history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DARB_IDLE;
      cnt_q   <= '0;
      last_q  <= DARB_M1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Registered bus, ack and read-data outputs so nothing toward the bridge glitches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner     <= DARB_M0;
      bus_addr  <= '0;
      bus_wen   <= 1'b0;
      bus_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      owner     <= owner_d;
      bus_addr  <= addr_d;
      bus_wen   <= wen_d;
      bus_wdata <= wdata_d;
      m0_ack    <= ack0_d;
      m1_ack    <= ack1_d;
      m0_rdata  <= rdata0_d;
      m1_rdata  <= rdata1_d;
    end
  end

`ifdef DBUS_ARB_PERF_EN
  // Count arbitration ties seen in IDLE and cycles the CPU spends stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_conflict <= '0;
      perf_stall    <= '0;
    end else begin
      if ((state_q == DARB_IDLE) && (req_eff == 2'b11)) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
      if (cpu_stall) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

  // Completion pulses are exclusive; two acks at once means the FSM is broken.
  a_one_ack : assert property (@(posedge clk_i) disable iff (rst_i) !(m0_ack && m1_ack));

endmodule
